// File: rtl/rob_commit_pkg.sv
// Shared sizing, index types and state encoding for the ROB retire stage.
package rob_commit_pkg;

    localparam int unsigned ROB_ENTRIES = 32;
    localparam int unsigned NUM_PREGS   = 64;
    localparam int unsigned NUM_AREGS   = 16;

    localparam int unsigned ROB_W  = $clog2(ROB_ENTRIES);
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);
    localparam int unsigned AREG_W = $clog2(NUM_AREGS);

    typedef logic [ROB_W-1:0]  rob_idx_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef enum logic {
        RUN,
        RESTORE
    } commit_state_t;

endpackage

// File: rtl/rob_commit_rat.sv
// Committed register alias table: one write port, two async read ports,
// reset to the identity mapping.
module committed_rat
    import rob_commit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  areg_t waddr,
    input  preg_t wdata,
    input  areg_t old_addr,
    output preg_t old_preg,
    input  areg_t restore_addr,
    output preg_t restore_preg
);

    preg_t crat [NUM_AREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) begin
                crat[i] <= preg_t'(i);
            end
        end else if (we) begin
            crat[waddr] <= wdata;
        end
    end

    assign old_preg     = crat[old_addr];
    assign restore_preg = crat[restore_addr];

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage: commits the ROB head, frees superseded pregs, and
// on exception/interrupt flushes then streams the committed map to rename.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    output rob_idx_t head_ptr,
    input  logic     head_valid,
    input  logic     head_busy,
    input  preg_t    head_preg,
    input  areg_t    head_areg,
    input  logic     head_exception,
    input  logic     head_mbegin,
    input  logic     head_mend,
    output logic     rob_pop,
    output logic     free_valid,
    output preg_t    free_preg,
    input  logic     irq_req,
    output logic     irq_ack,
    output logic     flush,
    output logic     exc_valid,
    output rob_idx_t exc_idx,
    output logic     restore_valid,
    output areg_t    restore_areg,
    output preg_t    restore_preg,
    output logic     restore_done
);

    commit_state_t state, state_next;
    rob_idx_t      head_next;
    logic          at_boundary, atb_next;
    areg_t         cnt, cnt_next;
    logic          free_next, done_next;
    logic          rat_we;
    logic          in_run, ready, take_irq, take_exc, commit;
    preg_t         old_preg, crat_rd;

    committed_rat u_crat (
        .clk          (clk),
        .rst          (rst),
        .we           (rat_we),
        .waddr        (head_areg),
        .wdata        (head_preg),
        .old_addr     (head_areg),
        .old_preg     (old_preg),
        .restore_addr (cnt),
        .restore_preg (crat_rd)
    );

    // The interrupt outranks a faulting head: that entry has not retired yet.
    assign in_run   = (state == RUN);
    assign ready    = head_valid & ~head_busy;
    assign take_irq = in_run & irq_req & at_boundary & head_valid;
    assign take_exc = in_run & ready & head_exception & ~take_irq;
    assign commit   = in_run & ready & ~head_exception & ~take_irq;

    assign exc_idx      = take_exc ? head_ptr : '0;
    assign restore_areg = (state == RESTORE) ? cnt : '0;
    assign restore_preg = (state == RESTORE) ? crat_rd : '0;

    always_comb begin
        state_next    = state;
        head_next     = head_ptr;
        atb_next      = at_boundary;
        cnt_next      = cnt;
        free_next     = 1'b0;
        done_next     = 1'b0;
        rat_we        = 1'b0;
        rob_pop       = 1'b0;
        flush         = 1'b0;
        exc_valid     = 1'b0;
        irq_ack       = 1'b0;
        restore_valid = 1'b0;
        unique case (state)
            RUN: begin
                if (take_irq || take_exc) begin
                    flush      = 1'b1;
                    exc_valid  = take_exc;
                    irq_ack    = take_irq;
                    head_next  = '0;
                    atb_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = RESTORE;
                end else if (commit) begin
                    rob_pop   = 1'b1;
                    head_next = head_ptr + rob_idx_t'(1);
                    rat_we    = (head_areg != '0);
                    free_next = (head_areg != '0);
                    if (head_mend) begin
                        atb_next = 1'b1;
                    end else if (head_mbegin) begin
                        atb_next = 1'b0;
                    end
                end
            end
            RESTORE: begin
                restore_valid = 1'b1;
                cnt_next      = cnt + areg_t'(1);
                if (cnt == areg_t'(NUM_AREGS - 1)) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            head_ptr     <= '0;
            at_boundary  <= 1'b1;
            cnt          <= '0;
            free_valid   <= 1'b0;
            free_preg    <= '0;
            restore_done <= 1'b0;
        end else begin
            state        <= state_next;
            head_ptr     <= head_next;
            at_boundary  <= atb_next;
            cnt          <= cnt_next;
            free_valid   <= free_next;
            restore_done <= done_next;
            if (free_next) begin
                free_preg <= old_preg;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with a reference model and a free-list scoreboard.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic     clk;
    logic     rst;
    rob_idx_t head_ptr;
    logic     head_valid, head_busy, head_exception, head_mbegin, head_mend;
    preg_t    head_preg;
    areg_t    head_areg;
    logic     rob_pop, free_valid;
    preg_t    free_preg;
    logic     irq_req, irq_ack, flush, exc_valid;
    rob_idx_t exc_idx;
    logic     restore_valid, restore_done;
    areg_t    restore_areg;
    preg_t    restore_preg;

    int compared   = 0;
    int mismatched = 0;

    int unsigned m_crat [NUM_AREGS];
    int unsigned m_head;
    bit          m_atb;
    bit          m_restore;
    int unsigned m_cnt;
    int unsigned free_q [$];

    rob_commit dut (
        .clk            (clk),
        .rst            (rst),
        .head_ptr       (head_ptr),
        .head_valid     (head_valid),
        .head_busy      (head_busy),
        .head_preg      (head_preg),
        .head_areg      (head_areg),
        .head_exception (head_exception),
        .head_mbegin    (head_mbegin),
        .head_mend      (head_mend),
        .rob_pop        (rob_pop),
        .free_valid     (free_valid),
        .free_preg      (free_preg),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack),
        .flush          (flush),
        .exc_valid      (exc_valid),
        .exc_idx        (exc_idx),
        .restore_valid  (restore_valid),
        .restore_areg   (restore_areg),
        .restore_preg   (restore_preg),
        .restore_done   (restore_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input int unsigned a, input int unsigned p,
                         input logic e, input logic mb, input logic me, input logic irq);
        head_valid     = v;
        head_busy      = b;
        head_areg      = areg_t'(a);
        head_preg      = preg_t'(p);
        head_exception = e;
        head_mbegin    = mb;
        head_mend      = me;
        irq_req        = irq;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_head_ptr", head_ptr, 0);
        chk("rst_free_valid", free_valid, 0);
        chk("rst_restore_valid", restore_valid, 0);
        chk("rst_restore_done", restore_done, 0);
        chk("rst_flush", flush, 0);
        chk("rst_rob_pop", rob_pop, 0);
        for (int i = 0; i < int'(NUM_AREGS); i++) m_crat[i] = i;
        m_head    = 0;
        m_atb     = 1'b1;
        m_restore = 1'b0;
        m_cnt     = 0;
        free_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic b, input int unsigned a, input int unsigned p,
                       input logic e, input logic mb, input logic me, input logic irq);
        bit ready, ti, te, cm, done_exp;
        @(negedge clk);
        drive(v, b, a, p, e, mb, me, irq);
        #1;
        done_exp = 1'b0;
        chk("head_ptr", head_ptr, m_head);
        if (!m_restore) begin
            ready = v & !b;
            ti    = irq & m_atb & v;
            te    = ready & e & !ti;
            cm    = ready & !e & !ti;
            chk("rob_pop", rob_pop, cm);
            chk("flush", flush, ti | te);
            chk("exc_valid", exc_valid, te);
            chk("irq_ack", irq_ack, ti);
            chk("restore_valid_run", restore_valid, 0);
            if (te) chk("exc_idx", exc_idx, m_head);
            if (ti || te) begin
                m_restore = 1'b1;
                m_cnt     = 0;
                m_head    = 0;
                m_atb     = 1'b1;
            end else if (cm) begin
                if (a != 0) begin
                    free_q.push_back(m_crat[a]);
                    m_crat[a] = p;
                end
                m_head = (m_head + 1) % ROB_ENTRIES;
                if (me) m_atb = 1'b1;
                else if (mb) m_atb = 1'b0;
            end
        end else begin
            chk("restore_valid", restore_valid, 1);
            chk("restore_areg", restore_areg, m_cnt);
            chk("restore_preg", restore_preg, m_crat[m_cnt]);
            chk("rob_pop_restore", rob_pop, 0);
            chk("flush_restore", flush, 0);
            if (m_cnt == NUM_AREGS - 1) begin
                m_restore = 1'b0;
                done_exp  = 1'b1;
            end
            m_cnt++;
        end
        @(posedge clk);
        #1;
        if (free_q.size() > 0) begin
            chk("free_valid", free_valid, 1);
            chk("free_preg", free_preg, free_q.pop_front());
        end else begin
            chk("free_valid_idle", free_valid, 0);
        end
        chk("restore_done", restore_done, done_exp);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Single commit, then an idle cycle to observe head_ptr = 1.
        reset_dut();
        cyc(1, 0, 3, 40, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Ordering: same areg twice gives frees 3 then 40; areg 0 frees nothing.
        reset_dut();
        cyc(1, 0, 3, 40, 0, 0, 0, 0);
        cyc(1, 0, 3, 41, 0, 0, 0, 0);
        cyc(1, 0, 0, 7, 0, 0, 0, 0);

        // Busy head stalls; empty ROB never takes an interrupt.
        repeat (5) cyc(1, 1, 2, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Wrap: 31 commits reach idx 31, one more wraps to 0.
        reset_dut();
        for (int i = 0; i < 31; i++) cyc(1, 0, i % 16, $urandom_range(63), 0, 0, 0, 0);
        cyc(1, 0, 5, 50, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Exception at idx 7 followed by the full restore stream.
        reset_dut();
        for (int i = 1; i <= 7; i++) cyc(1, 0, i, 20 + i, 0, 0, 0, 0);
        cyc(1, 0, 9, 60, 1, 0, 0, 0);
        repeat (16) cyc(1, 0, 4, 33, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Interrupt only at a macro-op boundary; it overrides a head exception.
        reset_dut();
        cyc(1, 0, 5, 30, 0, 1, 0, 0);
        cyc(1, 1, 6, 31, 0, 0, 0, 1);
        cyc(1, 0, 6, 31, 0, 0, 1, 1);
        cyc(1, 0, 7, 32, 1, 0, 0, 1);
        repeat (16) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset at beat 5 of a restore, then re-stream to see the identity map.
        cyc(1, 0, 2, 50, 0, 0, 0, 0);
        cyc(1, 0, 8, 0, 1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        reset_dut();
        cyc(1, 0, 8, 0, 1, 0, 0, 0);
        repeat (16) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 4, 44, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Retire stage directly downstream of the reorder buffer. Each cycle it examines the ROB head entry and retires at most one instruction, in order.
- On retirement it updates the committed register alias table (architectural to physical register mapping) and returns the superseded physical register to the free list.
- On an exception at the head, or an interrupt taken at a macro-op boundary, it flushes the pipeline. It then streams the committed mapping back to the rename stage so the rename table and free list can be rebuilt.

Parameters:
- ROB_ENTRIES, 32, number of ROB slots; power of two.
- NUM_PREGS, 64, number of physical registers.
- NUM_AREGS, 16, number of architectural registers; areg 0 is hardwired zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- head_ptr  out  $clog2(ROB_ENTRIES)  index of the ROB head entry
- head_valid  in  1  valid[head_ptr]
- head_busy  in  1  busy[head_ptr]
- head_preg  in  $clog2(NUM_PREGS)  preg[head_ptr]
- head_areg  in  $clog2(NUM_AREGS)  areg[head_ptr]
- head_exception  in  1  exception[head_ptr]
- head_mbegin  in  1  macroop_begin[head_ptr]
- head_mend  in  1  macroop_end[head_ptr]
- rob_pop  out  1  combinational; the ROB clears valid[head_ptr] at this edge
- free_valid  out  1  registered; free_preg returns to the free list
- free_preg  out  $clog2(NUM_PREGS)  physical register being freed
- irq_req  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse; interrupt taken
- flush  out  1  one-cycle pulse; all ROB entries and in-flight state are invalidated, and ROB head and tail reset to 0
- exc_valid  out  1  one-cycle pulse with flush; cause is an exception
- exc_idx  out  $clog2(ROB_ENTRIES)  head_ptr of the faulting entry
- restore_valid  out  1  restore stream beat
- restore_areg  out  $clog2(NUM_AREGS)  architectural register of this beat
- restore_preg  out  $clog2(NUM_PREGS)  committed physical register for restore_areg
- restore_done  out  1  one-cycle pulse after the final beat

Behaviour:
- Reset:
  - Outputs are 0 and the state is RUN.
  - crat[i] = i for all i.
  - at_boundary = 1.
- Conditions, evaluated in RUN only:
  - ready = head_valid & !head_busy.
  - take_irq = irq_req & at_boundary & head_valid.
  - take_exc = ready & head_exception & !take_irq. The interrupt wins because the head is not yet retired.
  - commit = ready & !head_exception & !take_irq.
- On commit:
  - rob_pop = 1 in the same cycle.
  - head_ptr increments at the next edge, wrapping from ROB_ENTRIES-1 to 0 via natural power-of-two overflow.
  - If head_areg != 0: at the next edge, crat[head_areg] <= head_preg, free_valid <= 1, free_preg <= old crat[head_areg].
  - If head_areg == 0: there is no crat update and no free.
  - at_boundary updates at the next edge:
    - set to 1 if head_mend;
    - else set to 0 if head_mbegin;
    - else unchanged.
- Empty ROB: head_valid = 0 means no pop and no interrupt. Interrupts are taken only ahead of a valid instruction.
- A busy head stalls retirement. The interrupt path is still evaluated.
- On take_exc or take_irq:
  - Assert flush for one cycle, plus exc_valid/exc_idx if exception, or irq_ack if interrupt.
  - rob_pop = 0; the faulting entry is not retired and nothing is freed.
  - head_ptr <= 0 and at_boundary <= 1.
  - State goes to RESTORE with cnt = 0.
- RESTORE:
  - Each cycle: restore_valid = 1, restore_areg = cnt, restore_preg = crat[cnt], then cnt++.
  - Takes exactly NUM_AREGS cycles.
  - After the final beat (cnt = NUM_AREGS-1), pulse restore_done next cycle and return to RUN.
  - Head inputs and irq_req are ignored; rob_pop and flush stay 0.
- free_valid is exactly one cycle wide per commit. Back-to-back commits give consecutive free pulses.
- Reset asserted mid-RESTORE aborts the stream immediately: restore_valid drops and the block returns to reset state.

Decomposition:
- Shared package holds:
  - ROB_ENTRIES, NUM_PREGS, NUM_AREGS;
  - rob_idx_t, preg_t, areg_t;
  - the commit state enum (RUN, RESTORE).
- Sub-module committed_rat holds the crat array:
  - one write port (areg, preg, we);
  - two async read ports (old-mapping read and restore read);
  - asynchronous reset to the identity mapping.

Test Plan:
- Single commit: reset, then head entry {valid, !busy, areg 3, preg 40} → rob_pop in the same cycle; next cycle free_valid = 1, free_preg = 3; head_ptr = 1; crat[3] = 40.
- Commit ordering: commit areg 3 to preg 40, then areg 3 to preg 41 → two consecutive free pulses, free_preg 3 then 40; areg 0 entry → pop with no free.
- Busy stall and wrap: head_busy = 1 for 5 cycles → no pop; set head_ptr to 31 via 31 commits, then 1 more commit → head_ptr = 0.
- Exception: head at idx 7 with exception = 1 → flush + exc_valid, exc_idx = 7, no pop; then 16 restore beats with areg 0..15 carrying the current crat values; restore_done; head_ptr = 0.
- Interrupt boundary: commit an entry with mbegin = 1, mend = 0, raise irq_req → no ack; commit an entry with mend = 1 → next cycle irq_ack + flush, and the head exception is ignored.
- Reset mid-RESTORE: assert rst at beat 5 → all outputs 0, crat is the identity mapping, state RUN.
